// File: rtl/md_unit.sv
// MIPS multiply/divide unit: owns HI/LO and runs MULT/MULTU/DIV/DIVU with a
// fixed busy latency. MTHI/MTLO write HI or LO directly while idle.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_res;
    logic          r_wr;
    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic signed [63:0] w_a_s;
    logic signed [63:0] w_b_s;
    logic [63:0]        w_mul_s;
    logic [63:0]        w_mul_u;
    logic [31:0]        w_rt_nz;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_dq;
    logic [31:0]        w_dr;
    logic [63:0]        w_res;
    logic               w_div_zero;

    assign w_a_s   = {{32{rs_data[31]}}, rs_data};
    assign w_b_s   = {{32{rt_data[31]}}, rt_data};
    assign w_mul_s = 64'(w_a_s * w_b_s);
    assign w_mul_u = {32'b0, rs_data} * {32'b0, rt_data};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_div_zero = (rt_data == '0);
    assign w_rt_nz    = w_div_zero ? 32'd1 : rt_data;
    assign w_abs_a    = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    assign w_abs_b    = w_rt_nz[31] ? (32'd0 - w_rt_nz) : w_rt_nz;
    assign w_uq       = w_abs_a / w_abs_b;
    assign w_ur       = w_abs_a % w_abs_b;
    assign w_sq       = (rs_data[31] ^ w_rt_nz[31]) ? (32'd0 - w_uq) : w_uq;
    assign w_sr       = rs_data[31] ? (32'd0 - w_ur) : w_ur;
    assign w_dq       = rs_data / w_rt_nz;
    assign w_dr       = rs_data % w_rt_nz;

    always_comb begin
        w_res = '0;
        case (md_op)
            3'd1:    w_res = w_mul_s;
            3'd2:    w_res = w_mul_u;
            3'd3:    w_res = {w_sr, w_sq};
            3'd4:    w_res = {w_dr, w_dq};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd1, 3'd2: begin
                                r_res   <= w_res;
                                r_wr    <= 1'b1;
                                r_cnt   <= CW'(MULT_CYCLES);
                                r_busy  <= 1'b1;
                                r_state <= S_BUSY;
                            end
                            3'd3, 3'd4: begin
                                r_res   <= w_res;
                                r_wr    <= ~w_div_zero;
                                r_cnt   <= CW'(DIV_CYCLES);
                                r_busy  <= 1'b1;
                                r_state <= S_BUSY;
                            end
                            3'd5:    r_hi <= rs_data;
                            3'd6:    r_lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        if (r_wr) begin
                            r_hi <= r_res[63:32];
                            r_lo <= r_res[31:0];
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan sequence followed by
// random traffic, compared every cycle against a timeline-based reference model.
module tb_md_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          commit_at = -1;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_wr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic, timing as "commit at issue + N".
    task automatic model_edge(input bit rst, input bit st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint unsigned ua, ub, up;
        longint p, q, r;
        bit was_busy;
        sa = a; sb = b; ua = a; ub = b;
        was_busy = (commit_at != -1);
        if (rst) begin
            m_hi = '0; m_lo = '0; commit_at = -1; p_wr = 1'b0;
        end else if (commit_at == cyc) begin
            if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            commit_at = -1;
        end else if (!was_busy && st) begin
            case (op)
                3'd1: begin
                    p = longint'(sa) * longint'(sb);
                    p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1'b1; commit_at = cyc + MC;
                end
                3'd2: begin
                    up = ua * ub;
                    p_hi = up[63:32]; p_lo = up[31:0]; p_wr = 1'b1; commit_at = cyc + MC;
                end
                3'd3: begin
                    p_wr = (b != 0);
                    if (b != 0) begin
                        q = longint'(sa) / longint'(sb);
                        r = longint'(sa) % longint'(sb);
                        p_hi = r[31:0]; p_lo = q[31:0];
                    end
                    commit_at = cyc + DC;
                end
                3'd4: begin
                    p_wr = (b != 0);
                    if (b != 0) begin
                        up = ua / ub; p_lo = up[31:0];
                        up = ua % ub; p_hi = up[31:0];
                    end
                    commit_at = cyc + DC;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        reset = rst; start = st; md_op = op; rs_data = a; rt_data = b;
        @(posedge clk);
        cyc++;
        model_edge(rst, st, op, a, b);
        #1;
        check_eq("busy", {31'b0, busy}, {31'b0, (commit_at != -1)});
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(1'b1, 1'b0, 3'd0, '0, '0);
        step(1'b1, 1'b0, 3'd0, '0, '0);

        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
        check_eq("mult_busy", {31'b0, busy}, 32'd1);
        idle(MC - 1);
        check_eq("mult_pre_hi", hi, 32'h0);
        idle(1);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);
        check_eq("mult_idle", {31'b0, busy}, 32'd0);

        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MC);
        check_eq("multu_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", lo, 32'h0000_0001);

        step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2);
        idle(DC);
        check_eq("divu_lo", lo, 32'd3);
        check_eq("divu_hi", hi, 32'd1);

        step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        check_eq("divovf_lo", lo, 32'h8000_0000);
        check_eq("divovf_hi", hi, 32'h0);

        step(1'b0, 1'b1, 3'd5, 32'h1234, '0);
        check_eq("mthi", hi, 32'h1234);
        check_eq("mthi_busy", {31'b0, busy}, 32'd0);
        step(1'b0, 1'b1, 3'd6, 32'h5678, '0);
        check_eq("mtlo", lo, 32'h5678);
        check_eq("mtlo_hi", hi, 32'h1234);

        step(1'b0, 1'b1, 3'd3, 32'd5, 32'd0);
        idle(DC - 1);
        check_eq("div0_busy", {31'b0, busy}, 32'd1);
        idle(1);
        check_eq("div0_hi", hi, 32'h1234);
        check_eq("div0_lo", lo, 32'h5678);

        step(1'b0, 1'b1, 3'd1, 32'd6, 32'd7);
        step(1'b0, 1'b1, 3'd5, 32'hAAAA, '0);
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd5);
        idle(MC - 2);
        check_eq("sb_hi", hi, 32'h0);
        check_eq("sb_lo", lo, 32'd42);
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
        check_eq("sb_accept", {31'b0, busy}, 32'd1);
        idle(DC);
        check_eq("sb_div_lo", lo, 32'd14);
        check_eq("sb_div_hi", hi, 32'd2);

        step(1'b0, 1'b1, 3'd3, 32'd1000, 32'd3);
        idle(2);
        step(1'b1, 1'b0, 3'd0, '0, '0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        idle(DC + 2);
        check_eq("rst_nocommit", lo, 32'h0);
        step(1'b0, 1'b1, 3'd1, 32'd3, 32'd4);
        idle(MC);
        check_eq("post_rst_mult", lo, 32'd12);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0), ($urandom_range(1) == 1),
                 3'($urandom_range(7)), pick_operand(), pick_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
